id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline register of the RV32I five-stage core: captures a decoded instruction, generates the immediate and the 4-bit ALU operation code, and drives the execute-stage ALU operands with EX/MEM and MEM/WB forwarding applied. It sits directly upstream of the ALU, whose `a_i`/`b_i`/`op_i` are fed from `a_o`/`b_o`/`op_o`. Stall and flush from the hazard unit control the register.

## Interface
- `XLEN`, 32, datapath width (fixed at 32 for RV32I)
- `clk_i`  in  1  clock, all state on rising edge
- `rst_ni`  in  1  asynchronous active-low reset
- `valid_i`  in  1  decode stage presents an instruction
- `instr_i`  in  32  raw instruction word
- `pc_i`  in  32  instruction address
- `rs1_data_i`, `rs2_data_i`  in  32 each  register-file read data
- `stall_i`  in  1  hold all stage registers
- `flush_i`  in  1  replace stage contents with a bubble
- `exmem_we_i`, `exmem_rd_i`, `exmem_res_i`  in  1/5/32  EX/MEM writeback info
- `memwb_we_i`, `memwb_rd_i`, `memwb_res_i`  in  1/5/32  MEM/WB writeback info
- `valid_o`  out  1  registered instruction valid
- `op_o`  out  4  ALU operation (registered)
- `a_o`, `b_o`  out  32  ALU operands (combinational from registered state and forward inputs)
- `store_data_o`  out  32  forwarded rs2 value for stores
- `rd_o`, `we_o`  out  5/1  destination register, writeback enable
- `mem_rd_o`, `mem_wr_o`, `funct3_o`  out  1/1/3  memory controls and access size
- `branch_o`, `pc_o`, `imm_o`  out  1/32/32  branch flag, PC, immediate
- `illegal_o`  out  1  registered: captured instruction had an unsupported opcode

## Operation
- Op codes: add 0000, sub 0001, sll 0010, slt 0011, sltu 0100, xor 0101, srl 0110, sra 0111, or 1000, and 1001, pass-b 1111.
- OP (0110011): a=rs1, b=rs2; funct3 selects op; funct7[5]=1 selects sub (funct3 000) or sra (funct3 101).
- OP-IMM (0010011): a=rs1, b=I-imm; funct3 000 is always add; srai when funct3 101 and funct7[5]=1.
- Shift ops (sll/srl/sra, register or immediate): b_o = {27'b0, b[4:0]}.
- LUI: op 1111, b=U-imm. AUIPC: add, a=pc, b=U-imm.
- LOAD/STORE: add, a=rs1, b=I-imm/S-imm; mem_rd_o/mem_wr_o set; store_data_o=forwarded rs2.
- JAL/JALR: add, a=pc, b=32'd4 (link value); imm_o=J-/I-imm.
- BRANCH: sub, a=rs1, b=rs2, branch_o=1, imm_o=B-imm.
- we_o=1 only for OP, OP-IMM, LUI, AUIPC, LOAD, JAL, JALR, and only when rd≠0.
- Any other opcode: illegal_o=1, valid_o=0, we_o/mem_rd_o/mem_wr_o/branch_o=0.
- Forwarding, per source register rs: EX/MEM hit if exmem_we_i and exmem_rd_i==rs and rs≠0. Otherwise MEM/WB hit under the same rule. Otherwise the registered read data. EX/MEM has priority. Register x0 is never forwarded and always reads 0.
- Forwarding applies only where the source is rs1/rs2, never where it is pc, imm or 4.

## Timing
- Reset (async assert, sync deassert by rst_ni): every registered field is 0, giving valid_o=0 and op_o=0000. Captured rs indices are 0, so a_o=b_o=store_data_o=0 during reset.
- Latency: one cycle from valid_i/instr_i to registered outputs. a_o/b_o follow the forward inputs in the same cycle.
- Edge priority: flush_i > stall_i > load.
  - flush_i: bubble, with valid_o, we_o, mem_rd_o, mem_wr_o, branch_o and illegal_o all 0.
  - stall_i: all registers hold. Forward muxes stay live, so operands track new EX/MEM and MEM/WB values.
  - load with valid_i=0: captures a bubble.
- Bubble control fields are 0. Data fields in a bubble are don't-care for verification.
- flush_i and stall_i asserted together produce a bubble.

## Test plan
- Reset with rst_ni=0 mid-cycle -> all outputs 0 immediately, no clock edge required.
- `add x3,x1,x2` with rs1=5, rs2=7 -> next cycle op_o=0000, a_o=5, b_o=7, we_o=1, rd_o=3. With funct7[5]=1 -> op_o=0001.
- `srai x4,x1,3` with rs1=0x80000000 -> op_o=0111, b_o=3. `slli` with imm 0x7E3 -> b_o=3.
- Forward x1: exmem hit 0xAAAA and memwb hit 0xBBBB -> a_o=0xAAAA. Drop exmem_we_i -> a_o=0xBBBB. rs1=x0 with both hits on rd=0 -> a_o=0.
- stall_i for 3 cycles with instr_i changing -> outputs hold the first instruction. flush_i with stall_i -> valid_o=0, we_o=0.
- `lui x5,0x12345` -> op_o=1111, b_o=0x12345000. `jal` at pc 0x100 -> a_o=0x100, b_o=4. Opcode 0x7F -> illegal_o=1, valid_o=0.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: bundles the decode-side inputs, hazard controls, forwarding
// sources and execute-side outputs of the ID/EX pipeline register.
//   master : upstream (decode, hazard unit, later stages) drives *_i, reads *_o
//   slave  : the id_ex_stage itself
// Signals:
//   valid_i, instr_i, pc_i, rs1_data_i, rs2_data_i   decoded instruction in
//   stall_i, flush_i                                 hazard-unit control
//   exmem_we_i/rd_i/res_i, memwb_we_i/rd_i/res_i     forwarding sources
//   valid_o, op_o, a_o, b_o, store_data_o, rd_o, we_o,
//   mem_rd_o, mem_wr_o, funct3_o, branch_o, pc_o, imm_o, illegal_o
interface id_ex_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            valid_i;
    logic [31:0]     instr_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic            stall_i;
    logic            flush_i;
    logic            exmem_we_i;
    logic [4:0]      exmem_rd_i;
    logic [XLEN-1:0] exmem_res_i;
    logic            memwb_we_i;
    logic [4:0]      memwb_rd_i;
    logic [XLEN-1:0] memwb_res_i;

    logic            valid_o;
    logic [3:0]      op_o;
    logic [XLEN-1:0] a_o;
    logic [XLEN-1:0] b_o;
    logic [XLEN-1:0] store_data_o;
    logic [4:0]      rd_o;
    logic            we_o;
    logic            mem_rd_o;
    logic            mem_wr_o;
    logic [2:0]      funct3_o;
    logic            branch_o;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] imm_o;
    logic            illegal_o;

    modport master (
        output valid_i, instr_i, pc_i, rs1_data_i, rs2_data_i, stall_i, flush_i,
               exmem_we_i, exmem_rd_i, exmem_res_i, memwb_we_i, memwb_rd_i, memwb_res_i,
        input  valid_o, op_o, a_o, b_o, store_data_o, rd_o, we_o, mem_rd_o, mem_wr_o,
               funct3_o, branch_o, pc_o, imm_o, illegal_o
    );

    modport slave (
        input  valid_i, instr_i, pc_i, rs1_data_i, rs2_data_i, stall_i, flush_i,
               exmem_we_i, exmem_rd_i, exmem_res_i, memwb_we_i, memwb_rd_i, memwb_res_i,
        output valid_o, op_o, a_o, b_o, store_data_o, rd_o, we_o, mem_rd_o, mem_wr_o,
               funct3_o, branch_o, pc_o, imm_o, illegal_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I decode-to-execute pipeline register. Decodes the incoming
// instruction (ALU op, immediate, operand sources, memory/writeback controls),
// registers it, and drives the ALU operands with EX/MEM > MEM/WB forwarding.
// Ports:
//   clk_i   clock, all state on the rising edge
//   rst_ni  asynchronous active-low reset, clears every registered field
//   bus     id_ex_stage_if.slave, decode inputs / hazard controls / forwarding
//           sources in, execute-stage controls and operands out
module id_ex_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    id_ex_stage_if.slave  bus
);

    localparam logic [3:0] OpAdd   = 4'b0000;
    localparam logic [3:0] OpSub   = 4'b0001;
    localparam logic [3:0] OpSll   = 4'b0010;
    localparam logic [3:0] OpSlt   = 4'b0011;
    localparam logic [3:0] OpSltu  = 4'b0100;
    localparam logic [3:0] OpXor   = 4'b0101;
    localparam logic [3:0] OpSrl   = 4'b0110;
    localparam logic [3:0] OpSra   = 4'b0111;
    localparam logic [3:0] OpOr    = 4'b1000;
    localparam logic [3:0] OpAnd   = 4'b1001;
    localparam logic [3:0] OpPassB = 4'b1111;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;

    // Zero encoding is rs2 so a reset/flushed stage yields b_o = x0 = 0.
    typedef enum logic [1:0] {BSelRs2, BSelImm, BSelFour} b_sel_e;

    typedef struct packed {
        logic            valid;
        logic            illegal;
        logic [3:0]      op;
        logic [4:0]      rd;
        logic            we;
        logic            mem_rd;
        logic            mem_wr;
        logic [2:0]      funct3;
        logic            branch;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic            a_pc;
        b_sel_e          b_sel;
    } stage_t;

    stage_t stage_d, stage_q;

    // funct7[5] only modifies funct3 000 (sub) and 101 (sra); callers mask it for OP-IMM.
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? OpSub : OpAdd;
            3'b001:  op = OpSll;
            3'b010:  op = OpSlt;
            3'b011:  op = OpSltu;
            3'b100:  op = OpXor;
            3'b101:  op = alt ? OpSra : OpSrl;
            3'b110:  op = OpOr;
            default: op = OpAnd;
        endcase
        return op;
    endfunction

    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic            alt;
    logic            writes;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign instr  = bus.instr_i;
    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign alt    = instr[30];

    assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
    assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21],
                    1'b0};

    always_comb begin
        stage_d          = '0;
        writes           = 1'b0;
        stage_d.rd       = instr[11:7];
        stage_d.funct3   = f3;
        stage_d.pc       = bus.pc_i;
        stage_d.rs1      = instr[19:15];
        stage_d.rs2      = instr[24:20];
        stage_d.rs1_data = bus.rs1_data_i;
        stage_d.rs2_data = bus.rs2_data_i;
        stage_d.op       = OpAdd;
        stage_d.b_sel    = BSelRs2;

        if (bus.valid_i) begin
            stage_d.valid = 1'b1;
            unique case (opcode)
                OpcOp: begin
                    stage_d.op = alu_op(f3, alt);
                    writes     = 1'b1;
                end
                OpcOpImm: begin
                    stage_d.op    = alu_op(f3, alt && (f3 == 3'b101));
                    stage_d.b_sel = BSelImm;
                    stage_d.imm   = imm_i;
                    writes        = 1'b1;
                end
                OpcLui: begin
                    stage_d.op    = OpPassB;
                    stage_d.b_sel = BSelImm;
                    stage_d.imm   = imm_u;
                    writes        = 1'b1;
                end
                OpcAuipc: begin
                    stage_d.a_pc  = 1'b1;
                    stage_d.b_sel = BSelImm;
                    stage_d.imm   = imm_u;
                    writes        = 1'b1;
                end
                OpcLoad: begin
                    stage_d.b_sel  = BSelImm;
                    stage_d.imm    = imm_i;
                    stage_d.mem_rd = 1'b1;
                    writes         = 1'b1;
                end
                OpcStore: begin
                    stage_d.b_sel  = BSelImm;
                    stage_d.imm    = imm_s;
                    stage_d.mem_wr = 1'b1;
                end
                OpcJal, OpcJalr: begin
                    // ALU computes the link address; the target uses imm_o downstream.
                    stage_d.a_pc  = 1'b1;
                    stage_d.b_sel = BSelFour;
                    stage_d.imm   = (opcode == OpcJal) ? imm_j : imm_i;
                    writes        = 1'b1;
                end
                OpcBranch: begin
                    stage_d.op     = OpSub;
                    stage_d.imm    = imm_b;
                    stage_d.branch = 1'b1;
                end
                default: begin
                    stage_d.valid   = 1'b0;
                    stage_d.illegal = 1'b1;
                end
            endcase
        end
        stage_d.we = writes && (stage_d.rd != 5'd0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else if (bus.flush_i) begin
            stage_q <= '0;
        end else if (!bus.stall_i) begin
            stage_q <= stage_d;
        end
    end

    // Forwarding stays live during stalls so held operands pick up newer results.
    logic [XLEN-1:0] rs1_val, rs2_val, a_val, b_val;
    logic            shift_op;

    always_comb begin
        rs1_val = '0;
        if (stage_q.rs1 != 5'd0) begin
            if (bus.exmem_we_i && (bus.exmem_rd_i == stage_q.rs1)) begin
                rs1_val = bus.exmem_res_i;
            end else if (bus.memwb_we_i && (bus.memwb_rd_i == stage_q.rs1)) begin
                rs1_val = bus.memwb_res_i;
            end else begin
                rs1_val = stage_q.rs1_data;
            end
        end

        rs2_val = '0;
        if (stage_q.rs2 != 5'd0) begin
            if (bus.exmem_we_i && (bus.exmem_rd_i == stage_q.rs2)) begin
                rs2_val = bus.exmem_res_i;
            end else if (bus.memwb_we_i && (bus.memwb_rd_i == stage_q.rs2)) begin
                rs2_val = bus.memwb_res_i;
            end else begin
                rs2_val = stage_q.rs2_data;
            end
        end

        a_val = stage_q.a_pc ? stage_q.pc : rs1_val;

        unique case (stage_q.b_sel)
            BSelRs2:  b_val = rs2_val;
            BSelImm:  b_val = stage_q.imm;
            BSelFour: b_val = XLEN'(4);
            default:  b_val = '0;
        endcase

        shift_op = (stage_q.op == OpSll) || (stage_q.op == OpSrl) || (stage_q.op == OpSra);
        if (shift_op) begin
            b_val = {{(XLEN-5){1'b0}}, b_val[4:0]};
        end
    end

    assign bus.valid_o      = stage_q.valid;
    assign bus.op_o         = stage_q.op;
    assign bus.a_o          = a_val;
    assign bus.b_o          = b_val;
    assign bus.store_data_o = rs2_val;
    assign bus.rd_o         = stage_q.rd;
    assign bus.we_o         = stage_q.we;
    assign bus.mem_rd_o     = stage_q.mem_rd;
    assign bus.mem_wr_o     = stage_q.mem_wr;
    assign bus.funct3_o     = stage_q.funct3;
    assign bus.branch_o     = stage_q.branch;
    assign bus.pc_o         = stage_q.pc;
    assign bus.imm_o        = stage_q.imm;
    assign bus.illegal_o    = stage_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(32)) bus ();

    id_ex_stage #(.XLEN(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        v;
        logic [31:0] instr, pc, r1, r2;
        logic        xwe;
        logic [4:0]  xrd;
        logic [31:0] xres;
        logic        wwe;
        logic [4:0]  wrd;
        logic [31:0] wres;
    } stim_t;

    typedef struct {
        logic        v, ill, we, mrd, mwr, br;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] a, b, pc, imm, sd;
        logic        chk_a, chk_imm, chk_sd;
    } exp_t;

    typedef struct {
        stim_t       s;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic        chk_a, we, v, ill;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    function automatic stim_t mk(logic [31:0] instr, logic [31:0] pc, logic [31:0] r1,
                                 logic [31:0] r2, logic xwe, logic [4:0] xrd, logic [31:0] xres,
                                 logic wwe, logic [4:0] wrd, logic [31:0] wres);
        stim_t s;
        s.v = 1'b1; s.instr = instr; s.pc = pc; s.r1 = r1; s.r2 = r2;
        s.xwe = xwe; s.xrd = xrd; s.xres = xres; s.wwe = wwe; s.wrd = wrd; s.wres = wres;
        return s;
    endfunction

    // Value a source register should present, given the current forwarding sources.
    function automatic logic [31:0] src(logic [4:0] r, logic [31:0] rf, stim_t f);
        if (r == 5'd0) return 32'd0;
        if (f.xwe && f.xrd == r) return f.xres;
        if (f.wwe && f.wrd == r) return f.wres;
        return rf;
    endfunction

    function automatic logic [3:0] alu(logic [2:0] f3, logic alt);
        case (f3)
            3'd0: return alt ? 4'd1 : 4'd0;
            3'd1: return 4'd2;
            3'd2: return 4'd3;
            3'd3: return 4'd4;
            3'd4: return 4'd5;
            3'd5: return alt ? 4'd7 : 4'd6;
            3'd6: return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    // Reference: captured instruction c evaluated against forwarding state f.
    function automatic exp_t model(stim_t c, stim_t f);
        exp_t e = '{default: 0};
        logic [31:0] i, x1, x2, ii, is, ib, iu, ij;
        logic wr = 1'b0;
        if (!c.v) return e;
        i  = c.instr;
        ii = 32'($signed(i) >>> 20);
        is = 32'($signed({i[31:25], i[11:7], 20'b0}) >>> 20);
        ib = 32'($signed({i[31], i[7], i[30:25], i[11:8], 20'b0}) >>> 19);
        ij = 32'($signed({i[31], i[19:12], i[20], i[30:21], 12'b0}) >>> 11);
        iu = {i[31:12], 12'b0};
        x1 = src(i[19:15], c.r1, f);
        x2 = src(i[24:20], c.r2, f);
        e.v = 1'b1; e.rd = i[11:7]; e.f3 = i[14:12]; e.pc = c.pc;
        e.chk_a = 1'b1; e.chk_imm = 1'b1; e.sd = x2;
        case (i[6:0])
            7'h33: begin e.op = alu(i[14:12], i[30]); e.a = x1; e.b = x2; wr = 1; e.chk_imm = 0; end
            7'h13: begin e.op = alu(i[14:12], i[30] && i[14:12] == 3'd5); e.a = x1; e.b = ii;
                         e.imm = ii; wr = 1; end
            7'h37: begin e.op = 4'hF; e.b = iu; e.imm = iu; e.chk_a = 0; wr = 1; end
            7'h17: begin e.a = c.pc; e.b = iu; e.imm = iu; wr = 1; end
            7'h03: begin e.a = x1; e.b = ii; e.imm = ii; e.mrd = 1; wr = 1; end
            7'h23: begin e.a = x1; e.b = is; e.imm = is; e.mwr = 1; e.chk_sd = 1; end
            7'h6F: begin e.a = c.pc; e.b = 4; e.imm = ij; wr = 1; end
            7'h67: begin e.a = c.pc; e.b = 4; e.imm = ii; wr = 1; end
            7'h63: begin e.op = 4'd1; e.a = x1; e.b = x2; e.imm = ib; e.br = 1; end
            default: begin e = '{default: 0}; e.ill = 1'b1; return e; end
        endcase
        if (e.op == 4'd2 || e.op == 4'd6 || e.op == 4'd7) e.b = e.b & 32'd31;
        e.we = wr && (e.rd != 5'd0);
        return e;
    endfunction

    task automatic check_exp(input string tag, input exp_t e);
        chk({tag, ".valid"}, 32'(bus.valid_o), 32'(e.v));
        chk({tag, ".illegal"}, 32'(bus.illegal_o), 32'(e.ill));
        chk({tag, ".we"}, 32'(bus.we_o), 32'(e.we));
        chk({tag, ".mem_rd"}, 32'(bus.mem_rd_o), 32'(e.mrd));
        chk({tag, ".mem_wr"}, 32'(bus.mem_wr_o), 32'(e.mwr));
        chk({tag, ".branch"}, 32'(bus.branch_o), 32'(e.br));
        if (e.v) begin
            chk({tag, ".op"}, 32'(bus.op_o), 32'(e.op));
            chk({tag, ".rd"}, 32'(bus.rd_o), 32'(e.rd));
            chk({tag, ".funct3"}, 32'(bus.funct3_o), 32'(e.f3));
            chk({tag, ".pc"}, bus.pc_o, e.pc);
            chk({tag, ".b"}, bus.b_o, e.b);
            if (e.chk_a) chk({tag, ".a"}, bus.a_o, e.a);
            if (e.chk_imm) chk({tag, ".imm"}, bus.imm_o, e.imm);
            if (e.chk_sd) chk({tag, ".store_data"}, bus.store_data_o, e.sd);
        end
    endtask

    task automatic apply(input stim_t s, input logic st, input logic fl);
        bus.valid_i     = s.v;
        bus.instr_i     = s.instr;
        bus.pc_i        = s.pc;
        bus.rs1_data_i  = s.r1;
        bus.rs2_data_i  = s.r2;
        bus.stall_i     = st;
        bus.flush_i     = fl;
        bus.exmem_we_i  = s.xwe;
        bus.exmem_rd_i  = s.xrd;
        bus.exmem_res_i = s.xres;
        bus.memwb_we_i  = s.wwe;
        bus.memwb_rd_i  = s.wrd;
        bus.memwb_res_i = s.wres;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".valid"}, 32'(bus.valid_o), 0);
        chk({tag, ".op"}, 32'(bus.op_o), 0);
        chk({tag, ".a"}, bus.a_o, 0);
        chk({tag, ".b"}, bus.b_o, 0);
        chk({tag, ".store_data"}, bus.store_data_o, 0);
        chk({tag, ".we"}, 32'(bus.we_o), 0);
        chk({tag, ".illegal"}, 32'(bus.illegal_o), 0);
        chk({tag, ".mem_wr"}, 32'(bus.mem_wr_o), 0);
    endtask

    function automatic stim_t rnd_stim();
        stim_t s;
        logic [6:0] opc;
        case ($urandom_range(0, 10))
            0: opc = 7'h33;  1: opc = 7'h13;  2: opc = 7'h37;  3: opc = 7'h17;
            4: opc = 7'h03;  5: opc = 7'h23;  6: opc = 7'h6F;  7: opc = 7'h67;
            8: opc = 7'h63;  9: opc = 7'h33;
            default: opc = ($urandom_range(0, 1) == 0) ? 7'h7F : 7'h0F;
        endcase
        s.instr        = $urandom;
        s.instr[6:0]   = opc;
        s.instr[11:7]  = 5'($urandom_range(0, 7));
        s.instr[19:15] = 5'($urandom_range(0, 7));
        s.instr[24:20] = 5'($urandom_range(0, 7));
        s.v    = ($urandom_range(0, 7) != 0);
        s.pc   = {$urandom, 2'b00} & 32'hFFFF_FFFC;
        s.r1   = $urandom;
        s.r2   = $urandom;
        s.xwe  = 1'($urandom_range(0, 1));
        s.xrd  = 5'($urandom_range(0, 7));
        s.xres = $urandom;
        s.wwe  = 1'($urandom_range(0, 1));
        s.wrd  = 5'($urandom_range(0, 7));
        s.wres = $urandom;
        return s;
    endfunction

    vec_t  vq[$];
    stim_t cap, nw, idle;

    task automatic add_vec(input stim_t s, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic chk_a, input logic we,
                           input logic v, input logic ill);
        vec_t t;
        t.s = s; t.op = op; t.a = a; t.b = b; t.chk_a = chk_a; t.we = we; t.v = v; t.ill = ill;
        vq.push_back(t);
    endtask

    initial begin
        idle = mk(32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle.v = 1'b0;
        apply(idle, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        add_vec(mk(32'h002081B3, 0, 5, 7, 0, 0, 0, 0, 0, 0), 4'h0, 5, 7, 1, 1, 1, 0);
        add_vec(mk(32'h402081B3, 0, 5, 7, 0, 0, 0, 0, 0, 0), 4'h1, 5, 7, 1, 1, 1, 0);
        add_vec(mk(32'h4030D213, 0, 32'h80000000, 0, 0, 0, 0, 0, 0, 0), 4'h7, 32'h80000000, 3,
                1, 1, 1, 0);
        add_vec(mk(32'h7E309213, 0, 32'h11, 0, 0, 0, 0, 0, 0, 0), 4'h2, 32'h11, 3, 1, 1, 1, 0);
        add_vec(mk(32'h123452B7, 0, 0, 0, 0, 0, 0, 0, 0, 0), 4'hF, 0, 32'h12345000, 0, 1, 1, 0);
        add_vec(mk(32'h000000EF, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0), 4'h0, 32'h100, 4, 1, 1, 1, 0);
        add_vec(mk(32'h0000007F, 0, 0, 0, 0, 0, 0, 0, 0, 0), 4'h0, 0, 0, 0, 0, 0, 1);
        add_vec(mk(32'hFFF00093, 0, 32'h55, 0, 0, 0, 0, 0, 0, 0), 4'h0, 0, 32'hFFFFFFFF, 1, 1,
                1, 0);
        add_vec(mk(32'h00208033, 0, 5, 7, 0, 0, 0, 0, 0, 0), 4'h0, 5, 7, 1, 0, 1, 0);
        add_vec(mk(32'h002081B3, 0, 5, 7, 1, 1, 32'hAAAA, 1, 1, 32'hBBBB), 4'h0, 32'hAAAA, 7,
                1, 1, 1, 0);
        add_vec(mk(32'h002081B3, 0, 5, 7, 0, 1, 32'hAAAA, 1, 1, 32'hBBBB), 4'h0, 32'hBBBB, 7,
                1, 1, 1, 0);
        add_vec(mk(32'h002001B3, 0, 32'h99, 7, 1, 0, 32'hAAAA, 1, 0, 32'hBBBB), 4'h0, 0, 7,
                1, 1, 1, 0);
        add_vec(mk(32'h0020A423, 0, 5, 7, 0, 0, 0, 0, 0, 0), 4'h0, 5, 8, 1, 0, 1, 0);
        add_vec(mk(32'h00208463, 0, 5, 7, 0, 0, 0, 0, 0, 0), 4'h1, 5, 7, 1, 0, 1, 0);
        add_vec(mk(32'h00001097, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0), 4'h0, 32'h200, 32'h1000,
                1, 1, 1, 0);

        foreach (vq[k]) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            @(negedge clk);
            apply(vq[k].s, 1'b0, 1'b0);
            @(posedge clk);
            #1;
            chk({tag, ".valid"}, 32'(bus.valid_o), 32'(vq[k].v));
            chk({tag, ".illegal"}, 32'(bus.illegal_o), 32'(vq[k].ill));
            chk({tag, ".we"}, 32'(bus.we_o), 32'(vq[k].we));
            if (vq[k].v) begin
                chk({tag, ".op"}, 32'(bus.op_o), 32'(vq[k].op));
                chk({tag, ".b"}, bus.b_o, vq[k].b);
                if (vq[k].chk_a) chk({tag, ".a"}, bus.a_o, vq[k].a);
            end
            check_exp({tag, ".m"}, model(vq[k].s, vq[k].s));
        end

        // Stall holds the first instruction while forwarding stays live.
        @(negedge clk);
        apply(mk(32'h002081B3, 32'h40, 5, 7, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
        @(posedge clk);
        #1 chk("stall.pre.a", bus.a_o, 5);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            apply(mk(32'h123452B7 + (k << 7), 32'h80 + k, 32'h77, 32'h66, 1, 1,
                     32'h1000 + k, 0, 0, 0), 1'b1, 1'b0);
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d.valid", k), 32'(bus.valid_o), 1);
            chk($sformatf("stall%0d.op", k), 32'(bus.op_o), 0);
            chk($sformatf("stall%0d.rd", k), 32'(bus.rd_o), 3);
            chk($sformatf("stall%0d.pc", k), bus.pc_o, 32'h40);
            chk($sformatf("stall%0d.a", k), bus.a_o, 32'h1000 + k);
            chk($sformatf("stall%0d.b", k), bus.b_o, 7);
        end
        @(negedge clk);
        apply(mk(32'h002081B3, 0, 5, 7, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("flushstall.valid", 32'(bus.valid_o), 0);
        chk("flushstall.we", 32'(bus.we_o), 0);

        // Asynchronous reset in the middle of a cycle.
        @(negedge clk);
        apply(mk(32'h0020A423, 0, 5, 7, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
        @(posedge clk);
        #1 chk("prerst.mem_wr", 32'(bus.mem_wr_o), 1);
        #2 rst_n = 1'b0;
        #1 check_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized run against the reference model.
        cap = idle;
        for (int n = 0; n < 400; n++) begin
            logic st, fl;
            nw = rnd_stim();
            st = ($urandom_range(0, 5) == 0);
            fl = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            apply(nw, st, fl);
            @(posedge clk);
            if (fl) cap = idle;
            else if (!st) cap = nw;
            #1 check_exp($sformatf("rnd%0d", n), model(cap, nw));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
